// File: rtl/arith_seq_pkg.sv
// Shared definitions for the arithmetic-unit sequencer: op codes, FSM states
// and the default datapath width.
package arith_seq_pkg;

  localparam int DEFAULT_WORD_W = 30;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREP      = 3'd1,
    ST_NEG       = 3'd2,
    ST_EXEC      = 3'd3,
    ST_MUL_EVAL  = 3'd4,
    ST_MUL_SHIFT = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_SHL);
  endfunction

endpackage

// File: rtl/arith_sequencer.sv
// Multi-cycle controller for the A/B/C arithmetic datapath: one op at a time on
// a start/done handshake, driving one-hot datapath strobes from the FSM state.
module arith_sequencer
  import arith_seq_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic [CNT_W-1:0] shl_count,
  input  logic             reg_b_0,
  input  logic             reg_c_30,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             result_flag,
  output logic             do_clear_b,
  output logic             do_not_a,
  output logic             do_sum,
  output logic             do_and,
  output logic             do_move_c_to_a,
  output logic             do_left_shift_b,
  output logic             do_right_shift_bc
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(WORD_W);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  // Next-state, latched op, iteration counter and captured flag
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op_sel;
          case (op_sel)
            OP_ADD, OP_SUB, OP_MUL: state_d = ST_PREP;
            OP_AND:                 state_d = ST_EXEC;
            OP_SHL: begin
              cnt_d   = shl_count;
              state_d = (shl_count == '0) ? ST_DONE : ST_EXEC;
            end
            default:                state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (op_q == OP_SUB) begin
          state_d = ST_NEG;
        end else if (op_q == OP_MUL) begin
          cnt_d   = CNT_MUL;
          state_d = ST_MUL_EVAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_NEG:       state_d = ST_EXEC;
      ST_EXEC: begin
        if (op_q == OP_SHL) begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_EXEC;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_MUL_EVAL:  state_d = ST_MUL_SHIFT;
      ST_MUL_SHIFT: begin
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_MUL_EVAL;
      end
      ST_DONE: begin
        flag_d  = reg_b_0;
        state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // Moore decode of the registered state; only the MUL add is gated by reg_c_30
  always_comb begin
    do_clear_b        = (state_q == ST_PREP) && (op_q == OP_MUL);
    do_move_c_to_a    = (state_q == ST_PREP) && (op_q != OP_MUL);
    do_not_a          = (state_q == ST_NEG);
    do_sum            = ((state_q == ST_EXEC) && ((op_q == OP_ADD) || (op_q == OP_SUB)))
                     || ((state_q == ST_MUL_EVAL) && reg_c_30);
    do_and            = (state_q == ST_EXEC) && (op_q == OP_AND);
    do_left_shift_b   = (state_q == ST_EXEC) && (op_q == OP_SHL);
    do_right_shift_bc = (state_q == ST_MUL_SHIFT);
    busy              = (state_q != ST_IDLE);
    done              = (state_q == ST_DONE);
    illegal           = (state_q == ST_DONE) && !is_legal_op(op_q);
    result_flag       = (state_q == ST_DONE) ? reg_b_0 : flag_q;
  end

endmodule

// File: tb/tb_arith_sequencer.sv
// Scoreboard bench: a datapath model closes the loop around the sequencer and
// an arithmetic reference predicts results, latency and strobe counts per op.
module tb_arith_sequencer;
  import arith_seq_pkg::*;

  localparam int W  = 30;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op_sel = 3'd0;
  logic [CW-1:0] shl_count = '0;
  logic          reg_b_0, reg_c_30;
  logic          busy, done, illegal, result_flag;
  logic          do_clear_b, do_not_a, do_sum, do_and, do_move_c_to_a;
  logic          do_left_shift_b, do_right_shift_bc;

  arith_sequencer #(.WORD_W(W), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_sel(op_sel),
    .shl_count(shl_count), .reg_b_0(reg_b_0), .reg_c_30(reg_c_30),
    .busy(busy), .done(done), .illegal(illegal), .result_flag(result_flag),
    .do_clear_b(do_clear_b), .do_not_a(do_not_a), .do_sum(do_sum),
    .do_and(do_and), .do_move_c_to_a(do_move_c_to_a),
    .do_left_shift_b(do_left_shift_b), .do_right_shift_bc(do_right_shift_bc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic unit model: A, B with overflow bit, C, carry_in
  logic [W-1:0] a_q = '0, b_q = '0, c_q = '0;
  logic         ovf_q = 1'b0, cin_q = 1'b0;
  logic         ld_en = 1'b0;
  logic [W-1:0] ld_a = '0, ld_b = '0, ld_c = '0;
  logic         ld_ovf = 1'b0;

  assign reg_b_0  = ovf_q;
  assign reg_c_30 = c_q[0];

  always @(posedge clk) begin
    if (ld_en) begin
      a_q <= ld_a; b_q <= ld_b; c_q <= ld_c; ovf_q <= ld_ovf; cin_q <= 1'b0;
    end else if (do_clear_b) begin
      b_q <= '0; ovf_q <= 1'b0; cin_q <= 1'b0;
    end else if (do_move_c_to_a) begin
      a_q <= c_q; cin_q <= 1'b0;
    end else if (do_not_a) begin
      a_q <= ~a_q; cin_q <= 1'b1;
    end else if (do_sum) begin
      {ovf_q, b_q} <= {1'b0, b_q} + {1'b0, a_q} + {{W{1'b0}}, cin_q};
    end else if (do_and) begin
      c_q <= a_q & c_q;
    end else if (do_left_shift_b) begin
      {ovf_q, b_q} <= {b_q, 1'b0};
    end else if (do_right_shift_bc) begin
      {ovf_q, b_q, c_q} <= {1'b0, ovf_q, b_q, c_q[W-1:1]};
    end
  end

  // Strobe index: 0 clear, 1 not, 2 sum, 3 and, 4 move, 5 lshift, 6 rshift
  logic [6:0] strb;
  assign strb = {do_right_shift_bc, do_left_shift_b, do_move_c_to_a, do_and,
                 do_sum, do_not_a, do_clear_b};

  typedef struct packed {
    logic [31:0]     acc;
    logic [31:0]     lat;
    logic            ill;
    logic            flag;
    logic [W-1:0]    b;
    logic [W-1:0]    c;
    logic [6:0][7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [W-1:0] c,
                                     input logic ovf, input logic [CW-1:0] n);
    exp_t        e;
    logic [60:0] t;
    logic [59:0] p;
    e = '0;
    e.b = b; e.c = c; e.flag = ovf;
    case (op)
      OP_ADD: begin
        t = {1'b0, b} + {1'b0, c};
        e.b = t[W-1:0]; e.flag = t[W]; e.lat = 32'd3;
        e.cnt[4] = 8'd1; e.cnt[2] = 8'd1;
      end
      OP_SUB: begin
        t = {1'b0, b} + {1'b0, ~c} + 31'd1;
        e.b = t[W-1:0]; e.flag = t[W]; e.lat = 32'd4;
        e.cnt[4] = 8'd1; e.cnt[1] = 8'd1; e.cnt[2] = 8'd1;
      end
      OP_AND: begin
        e.c = a & c; e.lat = 32'd2; e.cnt[3] = 8'd1;
      end
      OP_MUL: begin
        p = {30'd0, a} * {30'd0, c};
        e.b = p[59:30]; e.c = p[29:0]; e.flag = 1'b0; e.lat = 32'd62;
        e.cnt[0] = 8'd1; e.cnt[6] = 8'd30; e.cnt[2] = 8'($countones(c));
      end
      OP_SHL: begin
        e.lat = 32'(n) + 32'd1; e.cnt[5] = 8'(n);
        if (n != '0) begin
          t = {31'd0, b} << n;
          e.b = t[W-1:0]; e.flag = t[W];
        end
      end
      default: begin
        e.ill = 1'b1; e.lat = 32'd1;
      end
    endcase
    return e;
  endfunction

  // Monitor: accumulates strobes while busy, pops and compares on done
  logic [6:0][7:0] seen = '0;
  logic            multi = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      seen = '0; multi = 1'b0;
    end else begin
      for (int i = 0; i < 7; i++)
        if (strb[i]) seen[i] = seen[i] + 8'd1;
      if ($countones(strb) > 1) multi = 1'b1;
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("latency",     64'(cyc - int'(e.acc)), 64'(e.lat));
          check("illegal",     64'(illegal), 64'(e.ill));
          check("result_flag", 64'(result_flag), 64'(e.flag));
          check("reg_b",       64'(b_q), 64'(e.b));
          check("reg_c",       64'(c_q), 64'(e.c));
          check("strobe_cnt",  64'(seen), 64'(e.cnt));
          check("one_hot",     64'(multi), 64'd0);
          check("busy_in_done", 64'(busy), 64'd1);
        end
        seen = '0; multi = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic ovf, input logic [CW-1:0] n,
                        input bit poke);
    exp_t e;
    int   k;
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_b = b; ld_c = c; ld_ovf = ovf;
    @(negedge clk);
    ld_en = 1'b0;
    e = ref_model(op, a, b, c, ovf, n);
    e.acc = 32'(cyc);
    sb.push_back(e);
    start = 1'b1; op_sel = op; shl_count = n;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (10) @(negedge clk);
      start = 1'b1; op_sel = 3'($urandom_range(0, 7)); shl_count = CW'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: op %0d no done within %0d cycles", op, k);
      sb.delete();
    end else begin
      #1;
      check("flag_hold", 64'(result_flag), 64'(e.flag));
      check("idle_after_done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int acc;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [2:0] rop;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, illegal, result_flag, strb}), 64'd0);
    resetn = 1'b1;

    run_op(OP_ADD, 30'h1234, 30'd5, 30'd3, 1'b1, 5'd0, 1'b0);
    run_op(OP_SUB, 30'd0, 30'd5, 30'd3, 1'b0, 5'd0, 1'b0);
    run_op(OP_SUB, 30'd0, 30'd3, 30'd5, 1'b1, 5'd0, 1'b0);
    run_op(OP_AND, 30'h0F0F0F0F, 30'd7, 30'h3C3C3C3C, 1'b1, 5'd0, 1'b0);
    run_op(OP_MUL, 30'h20000000, 30'h155, 30'h20000000, 1'b1, 5'd0, 1'b0);
    run_op(OP_MUL, 30'h3FFFFFFF, 30'd0, 30'h3FFFFFFF, 1'b0, 5'd0, 1'b0);
    run_op(OP_SHL, 30'd0, 30'd1, 30'd9, 1'b1, 5'd29, 1'b0);
    run_op(OP_SHL, 30'd0, 30'd1, 30'd9, 1'b0, 5'd30, 1'b0);
    run_op(OP_SHL, 30'd0, 30'h2AAAAAAA, 30'd9, 1'b1, 5'd0, 1'b0);
    run_op(3'd6, 30'd1, 30'd2, 30'd3, 1'b1, 5'd4, 1'b0);
    run_op(OP_MUL, 30'h2345678, 30'd0, 30'h1ABCDEF, 1'b0, 5'd0, 1'b1);

    // Reset in MUL cycle 20: outputs clear next cycle and no done follows
    @(negedge clk);
    ld_en = 1'b1; ld_a = 30'h3FFFFFFF; ld_b = '0; ld_c = 30'h3FFFFFFF; ld_ovf = 1'b0;
    @(negedge clk);
    ld_en = 1'b0;
    acc = cyc;
    start = 1'b1; op_sel = OP_MUL;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 20) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_outputs", 64'({busy, done, illegal, result_flag, strb}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    run_op(OP_ADD, 30'd0, 30'h3FFFFFFF, 30'd1, 1'b0, 5'd0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, W'($urandom), W'($urandom), W'($urandom), 1'($urandom),
             CW'($urandom), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
